// File: rtl/min_pooling_mul_arbiter.sv
// Round-robin share of one 4-cycle ce-gated multiplier; products return MUL_LATENCY enabled cycles after issue.
// Backpressure: a stalled result consumer drops mul_ce, freezing the tag pipe and blocking every new issue.
module min_pooling_mul_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DIN0_WIDTH  = 62,
  parameter int DIN1_WIDTH  = 32,
  parameter int DOUT_WIDTH  = 64,
  parameter int MUL_LATENCY = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]      req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]      req_din1,
  output logic [NUM_REQ-1:0]                 resp_valid,
  input  logic [NUM_REQ-1:0]                 resp_ready,
  output logic [DOUT_WIDTH-1:0]              resp_dout,
  output logic                               mul_ce,
  output logic [DIN0_WIDTH-1:0]              mul_din0,
  output logic [DIN1_WIDTH-1:0]              mul_din1,
  input  logic [DOUT_WIDTH-1:0]              mul_dout,
  output logic [$clog2(MUL_LATENCY+1)-1:0]   in_flight,
  output logic                               idle
);

  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(MUL_LATENCY + 1);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  tag_t             tag_q [MUL_LATENCY];
  tag_t             tag_last;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;
  logic [NUM_REQ-1:0] grant;
  logic             stall;
  logic             issue;
  logic             complete;

  assign tag_last = tag_q[MUL_LATENCY-1];

  // Reset forces the pipe open so stale multiplier contents drain unseen.
  assign stall    = !reset && tag_last.vld && !resp_ready[tag_last.id];
  assign mul_ce   = !stall;
  assign complete = !reset && tag_last.vld && resp_ready[tag_last.id];

  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  assign grant     = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
  assign req_ready = grant & {NUM_REQ{!stall}};
  assign issue     = grant_any && !stall;

  // Operands go straight to the multiplier, which registers them on ce.
  assign mul_din0 = grant_any ? req_din0[grant_id*DIN0_WIDTH +: DIN0_WIDTH] : '0;
  assign mul_din1 = grant_any ? req_din1[grant_id*DIN1_WIDTH +: DIN1_WIDTH] : '0;

  assign resp_valid = (!reset && tag_last.vld) ? (NUM_REQ'(1) << tag_last.id) : '0;
  assign resp_dout  = mul_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else if (mul_ce) begin
      tag_q[0].vld <= issue;
      tag_q[0].id  <= grant_id;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight <= '0;
    end else begin
      case ({issue, complete})
        2'b10:   in_flight <= in_flight + CNTW'(1);
        2'b01:   in_flight <= in_flight - CNTW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign idle = (in_flight == '0) && !(|req_valid);

endmodule

// File: tb/tb_min_pooling_mul_arbiter.sv
// Scoreboard bench for min_pooling_mul_arbiter with a ce-gated multiplier model and a timing-level reference.
module tb_min_pooling_mul_arbiter;

  localparam int N  = 2;
  localparam int W0 = 62;
  localparam int W1 = 32;
  localparam int WO = 64;
  localparam int L  = 4;
  localparam int CW = $clog2(L + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W0-1:0]   req_din0;
  logic [N*W1-1:0]   req_din1;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [WO-1:0]     resp_dout;
  logic              mul_ce;
  logic [W0-1:0]     mul_din0;
  logic [W1-1:0]     mul_din1;
  logic [WO-1:0]     mul_dout;
  logic [CW-1:0]     in_flight;
  logic              idle;

  always #5 clk = ~clk;

  min_pooling_mul_arbiter #(
    .NUM_REQ(N), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WO), .MUL_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_dout(resp_dout),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .in_flight(in_flight), .idle(idle)
  );

  function automatic logic [63:0] ref_mul(input logic [W0-1:0] a, input logic [W1-1:0] b);
    logic signed [127:0] sa, sb, pr;
    sa = $signed({66'd0, a});
    sb = $signed({{96{b[W1-1]}}, b});
    pr = sa * sb;
    return pr[63:0];
  endfunction

  // External multiplier: input register plus three buffers, all ce-gated.
  logic [WO-1:0] mpipe [L];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= ref_mul(mul_din0, mul_din1);
      for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_dout = mpipe[L-1];

  typedef struct {
    int          id;
    logic [63:0] p;
    longint      e;
  } exp_t;

  exp_t        exp_q[$];
  longint      ecnt = 0;
  int          mptr = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] last_dout = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: derives expected timing from issue order and enabled-cycle count.
  bit          present, exp_stall, prev_stall;
  logic [63:0] prev_dout;
  int          pre, g, hid;
  logic [N-1:0] exp_rv, exp_rdy;
  initial begin
    prev_stall = 0;
    prev_dout  = '0;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mul_ce", 64'(mul_ce), 64'd1);
        exp_q.delete();
        mptr = 0;
        prev_stall = 0;
      end else begin
        pre = 0;
        foreach (exp_q[j]) if (exp_q[j].e != ecnt) pre++;
        present   = (exp_q.size() > 0) && (ecnt - exp_q[0].e == L);
        hid       = present ? exp_q[0].id : 0;
        exp_stall = present && !resp_ready[hid];
        exp_rv    = present ? (N'(1) << hid) : '0;
        check("mul_ce", 64'(mul_ce), 64'(!exp_stall));
        check("resp_valid", 64'(resp_valid), 64'(exp_rv));
        if (present) check("resp_dout", resp_dout, exp_q[0].p);
        if (prev_stall) check("dout_hold", resp_dout, prev_dout);
        g = -1;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (mptr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_rdy = (g >= 0 && !exp_stall) ? (N'(1) << g) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (exp_rdy != '0) mptr = (g + 1) % N;
        check("in_flight", 64'(in_flight), 64'(pre));
        check("idle", 64'(idle), 64'((pre == 0) && !(|req_valid)));
        if (present && resp_ready[hid]) begin
          last_dout = resp_dout;
          void'(exp_q.pop_front());
        end
        prev_stall = exp_stall;
        prev_dout  = resp_dout;
        if (!exp_stall) ecnt++;
      end
    end
  end

  // Stimulus
  bit [N-1:0]  pend;
  logic [W0-1:0] op0 [N];
  logic [W1-1:0] op1 [N];
  logic [N-1:0] rr_drv;
  bit          rst_drv;
  int          hs_cnt [N];

  task automatic step();
    @(negedge clk);
    reset      = rst_drv;
    req_valid  = pend;
    resp_ready = rr_drv;
    for (int i = 0; i < N; i++) begin
      req_din0[i*W0 +: W0] = op0[i];
      req_din1[i*W1 +: W1] = op1[i];
    end
    #3;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back('{id: i, p: ref_mul(op0[i], op1[i]), e: ecnt});
          pend[i] = 1'b0;
          hs_cnt[i]++;
        end
      end
    end
  endtask

  task automatic drain(input int n);
    pend = '0;
    rr_drv = '1;
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    pend = '0;
    step();
    rst_drv = 1'b0;
  endtask

  int h0, h1, ce_low;
  initial begin
    reset = 1'b1; req_valid = '0; resp_ready = '1; req_din0 = '0; req_din1 = '0;
    pend = '0; rr_drv = '1; rst_drv = 1'b1;
    for (int i = 0; i < N; i++) begin op0[i] = '0; op1[i] = '0; hs_cnt[i] = 0; end
    step(); step();
    rst_drv = 1'b0;

    // single op 3 * -5
    op0[0] = 62'd3; op1[0] = -32'sd5; pend = 2'b01;
    step();
    check("t1_issue", 64'(hs_cnt[0]), 64'd1);
    drain(8);
    check("t1_dout", last_dout, 64'hFFFF_FFFF_FFFF_FFF1);

    // both requesters back-to-back
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) begin
        op0[i] = W0'(i + 1); op1[i] = 32'd10; pend[i] = 1'b1;
      end
      step();
    end
    drain(8);
    check("t2_hs0", 64'(hs_cnt[0]), 64'd4);
    check("t2_hs1", 64'(hs_cnt[1]), 64'd3);

    // requester 1 stream with its consumer stalled for three cycles
    ce_low = 0;
    for (int s = 0; s < 12; s++) begin
      if (s < 8 && !pend[1]) begin
        op0[1] = W0'(s + 100); op1[1] = $urandom; pend[1] = 1'b1;
      end
      if (s >= 8) pend[1] = 1'b0;
      rr_drv = (s >= 4 && s <= 6) ? 2'b01 : 2'b11;
      step();
      if (!mul_ce) ce_low++;
    end
    check("t3_stall_cycles", 64'(ce_low), 64'd3);
    drain(8);

    // extreme operands
    op0[0] = 62'h2000_0000_0000_0000; op1[0] = 32'hFFFF_FFFF; pend = 2'b01;
    step(); drain(6);
    check("t4_neg", last_dout, 64'hE000_0000_0000_0000);
    op0[0] = '1; op1[0] = 32'h7FFF_FFFF; pend = 2'b01;
    step(); drain(6);
    check("t4_max", last_dout, 64'hBFFF_FFFF_8000_0001);

    // reset with three ops in flight
    for (int s = 0; s < 3; s++) begin
      op0[s % N] = W0'(s + 7); op1[s % N] = 32'd3; pend[s % N] = 1'b1;
      step();
      pend = '0;
    end
    do_reset();
    h0 = hs_cnt[0]; h1 = hs_cnt[1];
    op0[0] = 62'd5; op1[0] = 32'd6; op0[1] = 62'd8; op1[1] = 32'd9; pend = 2'b11;
    step();
    check("t5_first_grant0", 64'(hs_cnt[0] - h0), 64'd1);
    check("t5_first_grant1", 64'(hs_cnt[1] - h1), 64'd0);
    drain(10);

    // only requester 1 with pointer at 0
    do_reset();
    h1 = hs_cnt[1];
    op0[1] = 62'd11; op1[1] = -32'sd2; pend = 2'b10;
    step();
    check("t6_immediate", 64'(hs_cnt[1] - h1), 64'd1);
    drain(8);

    // randomized traffic
    for (int s = 0; s < 600; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 60) begin
          op0[i] = {$urandom, $urandom};
          op1[i] = $urandom;
          if ($urandom_range(0, 9) == 0) op0[i] = '1;
          pend[i] = 1'b1;
        end else if (pend[i] && $urandom_range(0, 99) < 10) begin
          op1[i] = $urandom;
        end
        rr_drv[i] = ($urandom_range(0, 99) < 75);
      end
      step();
    end
    drain(20);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
